// File: rtl/tea_pkg.sv
// Shared TEA constants, state encoding and the Feistel mixing function.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E37_79B9;
  localparam int          TEA_BLK_W = 64;
  localparam int          TEA_KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tea_state_e;

  // Mixing term shared by both halves of a Feistel cycle; shifts are logical.
  function automatic logic [31:0] tea_f(input logic [31:0] v,
                                        input logic [31:0] ka,
                                        input logic [31:0] kb,
                                        input logic [31:0] sum);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA Feistel cycle; encrypt or decrypt selected by mode.
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = TEA_DELTA
) (
  input  logic                 decrypt,
  input  logic [TEA_KEY_W-1:0] key,
  input  logic [31:0]          sum_in,
  input  logic [TEA_BLK_W-1:0] v_in,
  output logic [31:0]          sum_out,
  output logic [TEA_BLK_W-1:0] v_out
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] v0, v1, v0_n, v1_n, sum_enc;

  assign k0 = key[127:96];
  assign k1 = key[95:64];
  assign k2 = key[63:32];
  assign k3 = key[31:0];
  assign v0 = v_in[63:32];
  assign v1 = v_in[31:0];
  assign sum_enc = sum_in + DELTA;

  // Encrypt advances sum before mixing; decrypt mixes with the current sum and retreats it after.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    v0_n    = v0;
    v1_n    = v1;
    sum_out = sum_in;
    if (!decrypt) begin
      v0_n    = v0 + tea_f(v1, k0, k1, sum_enc);
      v1_n    = v1 + tea_f(v0_n, k2, k3, sum_enc);
      sum_out = sum_enc;
    end else begin
      v1_n    = v1 - tea_f(v0, k2, k3, sum_in);
      v0_n    = v0 - tea_f(v1_n, k0, k1, sum_in);
      sum_out = sum_in - DELTA;
    end
  end

  assign v_out = {v0_n, v1_n};

endmodule

// File: rtl/tea_iter_core.sv
// Iterative TEA core: one block in flight, UNROLL Feistel cycles per clock.
module tea_iter_core
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_decrypt,
  input  logic [TEA_KEY_W-1:0] in_key,
  input  logic [TEA_BLK_W-1:0] in_block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TEA_BLK_W-1:0] out_block,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(UNROLL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - UNROLL);
  // Decrypt starts from the sum the encryptor ends with.
  localparam logic [31:0]      SUM_DEC  = DELTA * 32'(ROUNDS);

  tea_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dec_q, dec_d;
  logic [TEA_KEY_W-1:0]   key_q, key_d;
  logic [TEA_BLK_W-1:0]   v_q, v_d;
  logic [31:0]            sum_q, sum_d;
  logic [TEA_BLK_W-1:0]   out_block_q, out_block_d;
  logic [TEA_BLK_W-1:0]   v_last;
  logic [31:0]            sum_last;

  // Chain UNROLL round instances; stage g feeds stage g+1 within one clock.
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [TEA_BLK_W-1:0] v_in, v_out;
    logic [31:0]          s_in, s_out;
    if (g == 0) begin : g_first
      assign v_in = v_q;
      assign s_in = sum_q;
    end else begin : g_next
      assign v_in = g_round[g-1].v_out;
      assign s_in = g_round[g-1].s_out;
    end
    tea_round #(.DELTA(DELTA)) u_round (
      .decrypt (dec_q),
      .key     (key_q),
      .sum_in  (s_in),
      .v_in    (v_in),
      .sum_out (s_out),
      .v_out   (v_out)
    );
  end

  assign v_last   = g_round[UNROLL-1].v_out;
  assign sum_last = g_round[UNROLL-1].s_out;

  // Next-state and datapath: latch on accept, iterate in RUN, hold the result in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    key_d       = key_q;
    v_d         = v_q;
    sum_d       = sum_q;
    out_block_d = out_block_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          dec_d   = in_decrypt;
          key_d   = in_key;
          v_d     = in_block;
          sum_d   = in_decrypt ? SUM_DEC : 32'h0;
          state_d = RUN;
        end
      end
      RUN: begin
        v_d   = v_last;
        sum_d = sum_last;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          out_block_d = v_last;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      key_q       <= '0;
      v_q         <= '0;
      sum_q       <= '0;
      out_block_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      key_q       <= key_d;
      v_q         <= v_d;
      sum_q       <= sum_d;
      out_block_q <= out_block_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_block = out_block_q;

endmodule

// File: tb/tb_tea_iter_core.sv
// Self-checking bench for tea_iter_core: vector table, scoreboard and corner-case sequences.
module tb_tea_iter_core;

  localparam logic [127:0] RT_KEY = 128'h12121212343434345656565678787878;
  localparam logic [63:0]  RT_PT  = 64'h1234567812345678;
  localparam logic [63:0]  ZERO_CT = 64'h41EA3A0A94BAA940;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_decrypt = 1'b0;
  logic [127:0] in_key = '0;
  logic [63:0]  in_block = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_block;
  logic         busy;

  // Shared stimulus for the UNROLL=2/4/8 instances.
  logic         ur_valid = 1'b0;
  logic         ur_decrypt = 1'b0;
  logic [63:0]  ur_block = '0;
  logic [2:0]   ur_in_ready, ur_out_valid, ur_busy;
  logic [63:0]  ur_out_block [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];

  typedef struct {
    bit           dec;
    logic [127:0] key;
    logic [63:0]  blk;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  tea_iter_core #(.ROUNDS(32), .UNROLL(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .in_key(in_key), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(2)) dut_u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(ur_valid), .in_ready(ur_in_ready[0]),
    .in_decrypt(ur_decrypt), .in_key(RT_KEY), .in_block(ur_block),
    .out_valid(ur_out_valid[0]), .out_ready(1'b1), .out_block(ur_out_block[0]), .busy(ur_busy[0])
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(4)) dut_u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(ur_valid), .in_ready(ur_in_ready[1]),
    .in_decrypt(ur_decrypt), .in_key(RT_KEY), .in_block(ur_block),
    .out_valid(ur_out_valid[1]), .out_ready(1'b1), .out_block(ur_out_block[1]), .busy(ur_busy[1])
  );

  tea_iter_core #(.ROUNDS(32), .UNROLL(8)) dut_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(ur_valid), .in_ready(ur_in_ready[2]),
    .in_decrypt(ur_decrypt), .in_key(RT_KEY), .in_block(ur_block),
    .out_valid(ur_out_valid[2]), .out_ready(1'b1), .out_block(ur_out_block[2]), .busy(ur_busy[2])
  );

  // Reference TEA, written as the classic loop over 32 cycles.
  function automatic logic [63:0] tea_model(input bit dec, input logic [127:0] k,
                                            input logic [63:0] b);
    logic [31:0] y, z, s;
    logic [31:0] d;
    d = 32'h9E3779B9;
    y = b[63:32];
    z = b[31:0];
    if (!dec) begin
      s = 32'h0;
      for (int r = 0; r < 32; r++) begin
        s = s + d;
        y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
        z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      end
    end else begin
      s = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
        y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
        s = s - d;
      end
    end
    return {y, z};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Scoreboard: a result is consumed when out_valid and out_ready meet at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_output: got %h expected none", out_block);
      end else begin
        check("sb_out_block", out_block, exp_q.pop_front());
      end
    end
  end

  // Wait for in_ready, present one request for one edge, and queue its expected result.
  task automatic send(input bit dec, input logic [127:0] key, input logic [63:0] blk,
                      input logic [63:0] exp);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("send_in_ready");
    in_valid   = 1'b1;
    in_decrypt = dec;
    in_key     = key;
    in_block   = blk;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Drive one request into the unrolled instances and check result and latency of each.
  task automatic run_ur(input bit dec, input logic [63:0] blk, input logic [63:0] exp);
    int lat [3];
    bit got [3];
    int exp_lat [3];
    exp_lat = '{17, 9, 5};
    got = '{0, 0, 0};
    lat = '{0, 0, 0};
    @(negedge clk);
    ur_valid   = 1'b1;
    ur_decrypt = dec;
    ur_block   = blk;
    @(posedge clk);
    #1;
    ur_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ur_out_valid[i] && !got[i]) begin
          got[i] = 1'b1;
          lat[i] = c;
          check($sformatf("unroll%0d_block", i), ur_out_block[i], exp);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!got[i]) fail_now($sformatf("unroll%0d_done", i));
      else check($sformatf("unroll%0d_latency", i), 64'(lat[i]), 64'(exp_lat[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [127:0] rkey;
    logic [63:0]  rblk, rt_ct, ct_tmp;
    int           c;

    rkey  = {$urandom, $urandom, $urandom, $urandom};
    rblk  = {$urandom, $urandom};
    rt_ct = tea_model(1'b0, RT_KEY, RT_PT);

    vecs[0] = '{dec: 1'b0, key: '0,     blk: '0,                            exp: ZERO_CT};
    vecs[1] = '{dec: 1'b1, key: '0,     blk: ZERO_CT,                       exp: '0};
    vecs[2] = '{dec: 1'b0, key: RT_KEY, blk: RT_PT,                         exp: rt_ct};
    vecs[3] = '{dec: 1'b1, key: RT_KEY, blk: rt_ct,                         exp: RT_PT};
    vecs[4] = '{dec: 1'b0, key: rkey,   blk: rblk,                          exp: tea_model(1'b0, rkey, rblk)};
    vecs[5] = '{dec: 1'b1, key: rkey,   blk: tea_model(1'b0, rkey, rblk),   exp: rblk};

    // Reset values while rst_n is held low.
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_block", out_block, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-key encrypt with exact latency measured in sampling edges after accept.
    send(1'b0, '0, '0, ZERO_CT);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c == 5) check("run_busy", 64'(busy), 64'd1);
      if (c == 5) check("run_in_ready", 64'(in_ready), 64'd0);
    end while (!out_valid && c < 100);
    check("enc_latency", 64'(c), 64'd33);
    drain();

    // Table of vectors, issued back to back.
    for (int i = 0; i < 6; i++) send(vecs[i].dec, vecs[i].key, vecs[i].blk, vecs[i].exp);
    drain();

    // Same round trip on UNROLL=2/4/8: identical ciphertext, plaintext recovered.
    run_ur(1'b0, RT_PT, rt_ct);
    run_ur(1'b1, rt_ct, RT_PT);

    // Backpressure: hold DONE for 10 clocks, then release for one.
    out_ready = 1'b0;
    send(1'b0, '0, '0, ZERO_CT);
    c = 0;
    while (!out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!out_valid) fail_now("bp_done");
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_block", out_block, ZERO_CT);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Inputs toggled and in_valid pulsed after accept must not disturb the result.
    send(1'b0, RT_KEY, RT_PT, rt_ct);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_key     = {$urandom, $urandom, $urandom, $urandom};
      in_block   = {$urandom, $urandom};
      in_decrypt = ~in_decrypt;
      in_valid   = (i % 2 == 0);
      if (i == 6) check("ignore_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("ignore_idle", 64'(in_ready), 64'd1);

    // Reset mid-RUN at round 17: outputs return to reset values without a clock edge.
    send(1'b0, '0, '0, ZERO_CT);
    repeat (16) @(posedge clk);
    #3;
    check("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_out_block", out_block, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, '0, '0, ZERO_CT);
    drain();
    check("post_rst_out_block", out_block, ZERO_CT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
